regbus_rr_arbiter: RTL and testbench

REGBUS_RR_ARBITER -- requirements
Module: regbus_rr_arbiter

---
 rtl/regbus_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_regbus_rr_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/regbus_rr_arbiter.sv
// Round-robin arbiter that shares one register-bus target between NumReq requesters,
// with zero-latency forwarding, a per-transaction timeout, and a saturating timeout counter.

package regbus_rr_arbiter_pkg;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;

  typedef struct packed {
    logic                   valid;
    logic                   write;
    logic [AddrWidth-1:0]   addr;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;
  } req_t;

  typedef struct packed {
    logic                 ready;
    logic [DataWidth-1:0] rdata;
    logic                 error;
  } rsp_t;
endpackage

module regbus_rr_arbiter #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned TimeoutCycles = 256,
  parameter type         req_t         = regbus_rr_arbiter_pkg::req_t,
  parameter type         rsp_t         = regbus_rr_arbiter_pkg::rsp_t,
  localparam int unsigned IdW          = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  req_t           req_i [NumReq],
  output rsp_t           rsp_o [NumReq],
  output req_t           req_o,
  input  rsp_t           rsp_i,
  output logic [IdW-1:0] grant_id_o,
  output logic           timeout_o,
  output logic [15:0]    timeout_cnt_o
);

  localparam bit          TimeoutEn  = (TimeoutCycles != 0);
  localparam logic [15:0] TimeoutVal = 16'(TimeoutCycles);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] lock_q, lock_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [15:0]    tcnt_q, tcnt_d;

  logic [IdW-1:0] winner;
  logic           any_valid;

  function automatic logic [IdW-1:0] next_idx(input logic [IdW-1:0] idx);
    return (idx == IdW'(NumReq - 1)) ? '0 : idx + IdW'(1);
  endfunction

  // First valid requester scanning upward from ptr_q, wrapping at NumReq.
  always_comb begin
    int unsigned idx;
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!any_valid && req_i[idx].valid) begin
        any_valid = 1'b1;
        winner    = IdW'(idx);
      end
    end
  end

  always_comb begin
    // NOTE: every output and next-state signal gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    cnt_d      = cnt_q;
    tcnt_d     = tcnt_q;
    req_o      = '0;
    rsp_o      = '{default: '0};
    grant_id_o = '0;
    timeout_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any_valid) begin
          req_o          = req_i[winner];
          grant_id_o     = winner;
          rsp_o[winner]  = rsp_i;
          if (rsp_i.ready) begin
            ptr_d = next_idx(winner);
          end else begin
            state_d = BUSY;
            lock_d  = winner;
            cnt_d   = 16'd1;
          end
        end
      end
      BUSY: begin
        grant_id_o = lock_q;
        if (TimeoutEn && (cnt_q == TimeoutVal)) begin
          // Target readiness is deliberately ignored here: the timeout wins.
          rsp_o[lock_q].ready = 1'b1;
          rsp_o[lock_q].error = 1'b1;
          timeout_o           = 1'b1;
          ptr_d               = next_idx(lock_q);
          state_d             = IDLE;
          if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
        end else if (!req_i[lock_q].valid) begin
          state_d = IDLE;
        end else begin
          req_o         = req_i[lock_q];
          rsp_o[lock_q] = rsp_i;
          if (rsp_i.ready) begin
            ptr_d   = next_idx(lock_q);
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Forwarding paths are combinational, so hold them quiet while reset is asserted.
    if (!rst_ni) begin
      req_o     = '0;
      rsp_o     = '{default: '0};
      timeout_o = 1'b0;
    end
  end

  assign timeout_cnt_o = tcnt_d;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_regbus_rr_arbiter.sv
// Table-driven bench for regbus_rr_arbiter with NumReq=3, TimeoutCycles=8; each table row is
// one clock cycle of stimulus plus the expected outputs, routed through an expectation queue.

module tb_regbus_rr_arbiter;
  import regbus_rr_arbiter_pkg::*;

  localparam int unsigned N      = 3;
  localparam int unsigned TO     = 8;
  localparam logic [31:0] RDATA  = 32'hC0DE_5A5A;

  typedef struct {
    logic [2:0]  valid;
    logic        ready;
    logic        rst;
    logic        exp_valid;
    logic [1:0]  exp_gid;
    logic [2:0]  exp_rdy;
    logic        exp_to;
    logic [15:0] exp_tcnt;
  } vec_t;

  logic        clk;
  logic        rst_n;
  req_t        req_i [N];
  rsp_t        rsp_o [N];
  req_t        req_o;
  rsp_t        rsp_i;
  logic [1:0]  grant_id;
  logic        timeout;
  logic [15:0] timeout_cnt;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec;
  int   n_err;

  regbus_rr_arbiter #(
    .NumReq        (N),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req_i),
    .rsp_o         (rsp_o),
    .req_o         (req_o),
    .rsp_i         (rsp_i),
    .grant_id_o    (grant_id),
    .timeout_o     (timeout),
    .timeout_cnt_o (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  function automatic logic [31:0] addr_of(input int k);
    return 32'h4000_0000 + 32'(k) * 32'h10;
  endfunction

  function automatic logic [31:0] wdata_of(input int k);
    return 32'hA5A5_0000 | 32'(k);
  endfunction

  task automatic add(input int n, input logic [2:0] valid, input logic ready, input logic ev,
                     input logic [1:0] gid, input logic [2:0] rdy, input logic to,
                     input logic [15:0] tcnt, input logic rst = 1'b0);
    vec_t v;
    v.valid = valid; v.ready = ready; v.rst = rst; v.exp_valid = ev; v.exp_gid = gid;
    v.exp_rdy = rdy; v.exp_to = to; v.exp_tcnt = tcnt;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vector %0d): got %h, expected %h", name, n_vec, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    for (int k = 0; k < N; k++) begin
      req_i[k].valid = v.valid[k];
      req_i[k].write = k[0];
      req_i[k].addr  = addr_of(k);
      req_i[k].wdata = wdata_of(k);
      req_i[k].wstrb = 4'hF;
    end
    rsp_i.ready = v.ready;
    rsp_i.rdata = v.ready ? RDATA : 32'h0;
    rsp_i.error = 1'b0;
  endtask

  task automatic sample();
    vec_t e;
    logic [31:0] exp_rdata;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard (vector %0d): got empty queue, expected an entry", n_vec);
      return;
    end
    e = exp_q.pop_front();
    check("req_valid", 32'(req_o.valid), 32'(e.exp_valid));
    if (e.exp_valid) begin
      check("grant_id", 32'(grant_id), 32'(e.exp_gid));
      check("req_addr", req_o.addr, addr_of(int'(e.exp_gid)));
      check("req_wdata", req_o.wdata, wdata_of(int'(e.exp_gid)));
      check("req_write", 32'(req_o.write), 32'(e.exp_gid[0]));
    end
    for (int k = 0; k < N; k++) begin
      exp_rdata = (e.exp_rdy[k] && !e.exp_to) ? RDATA : 32'h0;
      check($sformatf("rsp%0d_ready", k), 32'(rsp_o[k].ready), 32'(e.exp_rdy[k]));
      check($sformatf("rsp%0d_error", k), 32'(rsp_o[k].error), 32'(e.exp_rdy[k] & e.exp_to));
      check($sformatf("rsp%0d_rdata", k), rsp_o[k].rdata, exp_rdata);
    end
    check("timeout", 32'(timeout), 32'(e.exp_to));
    check("timeout_cnt", 32'(timeout_cnt), 32'(e.exp_tcnt));
  endtask

  initial begin
    vec_t idle_v;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle_v = '{valid: 3'b000, ready: 1'b0, rst: 1'b0, exp_valid: 1'b0, exp_gid: 2'd0,
               exp_rdy: 3'b000, exp_to: 1'b0, exp_tcnt: 16'd0};
    drive(idle_v);

    // Reset held with every requester valid: nothing may leak through.
    add(1, 3'b111, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 16'd0, 1'b1);
    // Fairness: all valid, target always ready -> 0,1,2,0,1,2.
    for (int r = 0; r < 2; r++)
      for (int g = 0; g < 3; g++)
        add(1, 3'b111, 1'b1, 1'b1, 2'(g), 3'(1 << g), 1'b0, 16'd0);
    // Req1 held four cycles; others wait; req2 wins next.
    add(1, 3'b010, 1'b0, 1'b1, 2'd1, 3'b000, 1'b0, 16'd0);
    add(2, 3'b111, 1'b0, 1'b1, 2'd1, 3'b000, 1'b0, 16'd0);
    add(1, 3'b111, 1'b1, 1'b1, 2'd1, 3'b010, 1'b0, 16'd0);
    add(1, 3'b111, 1'b1, 1'b1, 2'd2, 3'b100, 1'b0, 16'd0);
    // Req0, target never ready -> timeout at T0+8.
    add(8, 3'b001, 1'b0, 1'b1, 2'd0, 3'b000, 1'b0, 16'd0);
    add(1, 3'b001, 1'b0, 1'b0, 2'd0, 3'b001, 1'b1, 16'd1);
    add(1, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 16'd1);
    // Ready first arrives at T0+8: timeout still wins.
    add(8, 3'b001, 1'b0, 1'b1, 2'd0, 3'b000, 1'b0, 16'd1);
    add(1, 3'b001, 1'b1, 1'b0, 2'd0, 3'b001, 1'b1, 16'd2);
    add(1, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 16'd2);
    // Ready at T0+7: normal completion, counter unchanged.
    add(7, 3'b001, 1'b0, 1'b1, 2'd0, 3'b000, 1'b0, 16'd2);
    add(1, 3'b001, 1'b1, 1'b1, 2'd0, 3'b001, 1'b0, 16'd2);
    add(1, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 16'd2);
    // Locked req1 drops valid at T0+2; ptr stays 1 so req1 beats req0 afterwards.
    add(2, 3'b010, 1'b0, 1'b1, 2'd1, 3'b000, 1'b0, 16'd2);
    add(1, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 16'd2);
    add(1, 3'b011, 1'b1, 1'b1, 2'd1, 3'b010, 1'b0, 16'd2);
    // Single requester across the wrap point is granted every time.
    add(3, 3'b100, 1'b1, 1'b1, 2'd2, 3'b100, 1'b0, 16'd2);
    // Reset during BUSY with req2 locked, then arbitration restarts from index 0.
    add(1, 3'b100, 1'b0, 1'b1, 2'd2, 3'b000, 1'b0, 16'd2);
    add(1, 3'b111, 1'b0, 1'b1, 2'd2, 3'b000, 1'b0, 16'd2);
    add(1, 3'b111, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 16'd0, 1'b1);
    add(1, 3'b110, 1'b1, 1'b1, 2'd1, 3'b010, 1'b0, 16'd0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst_n = !vecs[i].rst;
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      sample();
      n_vec++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
